// File: rtl/dac_tx_stage_if.sv
// AXI-Stream style word channel between the DAC output stage and one RF-DAC stream port.
// A word transfers on a clock edge where tvalid and tready are both 1; while tvalid=1 and
// tready=0 the master holds tdata unchanged, and tvalid never depends on tready.
interface dac_tx_stage_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dac_tx_stage.sv
// DAC output stage: soft mute/ramp gain on every lane, one register stage, then a small FIFO
// feeding an AXI-Stream master, with a saturating dropped-word counter.
module dac_tx_stage #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int RAMP_STEP      = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [16*NUMBER_OF_LINE-1:0]   s_data,
    input  logic                           s_valid,
    input  logic                           enable,
    dac_tx_stage_if.master                 m_axis,
    output logic [1:0]                     state,
    output logic [15:0]                    overflow_count,
    input  logic                           overflow_clear
);
    localparam int DW = 16 * NUMBER_OF_LINE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [8:0]    STEP9   = 9'(RAMP_STEP);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t          state_q;
    logic [8:0]      gain;
    logic [8:0]      up_g;
    logic [8:0]      dn_g;
    logic [9:0]      up_sum;
    logic [DW-1:0]   scaled;
    logic            s1_valid;
    logic [DW-1:0]   s1_data;
    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    // Q8 gain; the product always fits 24 bits because |s*g| <= 2^23.
    function automatic logic [15:0] scale_lane(input logic [15:0] s, input logic [8:0] g);
        logic signed [23:0] p;
        p = $signed({{8{s[15]}}, s}) * $signed({15'b0, g});
        return 16'(p >>> 8);
    endfunction

    always_comb begin
        up_sum = {1'b0, gain} + {1'b0, STEP9};
        up_g   = (up_sum >= 10'd256) ? 9'd256 : up_sum[8:0];
        dn_g   = (gain > STEP9) ? (gain - STEP9) : 9'd0;
    end

    always_comb begin
        scaled = '0;
        for (int k = 0; k < NUMBER_OF_LINE; k++) begin
            scaled[16*k +: 16] = scale_lane(s_data[16*k +: 16], gain);
        end
    end

    // Gain and state move only on valid words; the current word is scaled with the old gain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MUTED;
            gain    <= 9'd0;
        end else if (s_valid) begin
            case (state_q)
                MUTED: begin
                    if (enable) begin
                        gain    <= up_g;
                        state_q <= (up_g == 9'd256) ? ACTIVE : RAMP_UP;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (enable) begin
                        gain    <= up_g;
                        state_q <= (up_g == 9'd256) ? ACTIVE : RAMP_UP;
                    end else begin
                        gain    <= dn_g;
                        state_q <= (dn_g == 9'd0) ? MUTED : RAMP_DOWN;
                    end
                end
                ACTIVE: begin
                    if (!enable) begin
                        gain    <= dn_g;
                        state_q <= (dn_g == 9'd0) ? MUTED : RAMP_DOWN;
                    end
                end
                default: begin
                    state_q <= MUTED;
                    gain    <= 9'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= s_valid;
            if (s_valid) begin
                s1_data <= scaled;
            end
        end
    end

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    always_comb begin
        full    = (count == DEPTH_C);
        pop     = (count != '0) && m_axis.tready;
        push_ok = s1_valid && (!full || pop);
        drop    = s1_valid && full && !pop;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= s1_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_count <= 16'd0;
        end else if (overflow_clear) begin
            overflow_count <= 16'd0;
        end else if (drop && (overflow_count != 16'hFFFF)) begin
            overflow_count <= overflow_count + 16'd1;
        end
    end

    assign m_axis.tvalid = (count != '0);
    assign m_axis.tdata  = mem[rd_ptr];
    assign state         = state_q;
endmodule

// File: tb/tb_dac_tx_stage.sv
// Directed and randomized bench for dac_tx_stage against a word-level reference model.
module tb_dac_tx_stage;
    localparam int NL    = 8;
    localparam int DW    = 16 * NL;
    localparam int STEP  = 4;
    localparam int DEPTH = 8;

    logic          clock;
    logic          reset_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          enable;
    logic [1:0]    state;
    logic [15:0]   overflow_count;
    logic          overflow_clear;

    dac_tx_stage_if #(.DATA_W(DW)) axis_if ();

    dac_tx_stage #(
        .NUMBER_OF_LINE(NL),
        .RAMP_STEP(STEP),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .s_data(s_data),
        .s_valid(s_valid),
        .enable(enable),
        .m_axis(axis_if),
        .state(state),
        .overflow_count(overflow_count),
        .overflow_clear(overflow_clear)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: words in flight and the gain trajectory
    logic [DW-1:0] exp_q [$];
    logic          m_s1_valid;
    logic [DW-1:0] m_s1_data;
    int            m_g;
    int            m_state;
    int            m_ovf;

    int checks;
    int failures;

    function automatic logic [DW-1:0] fill(input logic [15:0] v);
        logic [DW-1:0] r;
        for (int k = 0; k < NL; k++) r[16*k +: 16] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_scale(input logic [DW-1:0] w, input int g);
        logic [DW-1:0] r;
        int p;
        for (int k = 0; k < NL; k++) begin
            p = int'($signed(w[16*k +: 16])) * g;
            r[16*k +: 16] = 16'(p >>> 8);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int k = 0; k < NL; k++) begin
            case ($urandom_range(0, 7))
                0:       r[16*k +: 16] = 16'h8000;
                1:       r[16*k +: 16] = 16'h7FFF;
                2:       r[16*k +: 16] = 16'hFFFF;
                3:       r[16*k +: 16] = 16'h0000;
                default: r[16*k +: 16] = 16'($urandom);
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_s1_valid = 1'b0;
        m_s1_data  = '0;
        m_g        = 0;
        m_state    = 0;
        m_ovf      = 0;
    endtask

    // Gain walks toward the target set by enable; state names where it sits on that walk.
    task automatic model_edge();
        bit pop;
        bit drop;
        int target;
        pop  = (exp_q.size() != 0) && axis_if.tready;
        drop = m_s1_valid && (exp_q.size() == DEPTH) && !pop;
        if (pop) void'(exp_q.pop_front());
        if (m_s1_valid && !drop) exp_q.push_back(m_s1_data);
        if (overflow_clear) m_ovf = 0;
        else if (drop && m_ovf < 65535) m_ovf++;
        m_s1_valid = s_valid;
        if (s_valid) begin
            m_s1_data = ref_scale(s_data, m_g);
            target = enable ? 256 : 0;
            if (m_g < target) m_g = (m_g + STEP > 256) ? 256 : m_g + STEP;
            else if (m_g > target) m_g = (m_g - STEP < 0) ? 0 : m_g - STEP;
            if (enable) m_state = (m_g == 256) ? 2 : 1;
            else        m_state = (m_g == 0) ? 0 : 3;
        end
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("tvalid", DW'(axis_if.tvalid), DW'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("tdata", axis_if.tdata, exp_q[0]);
        check("state", DW'(state), DW'(m_state));
        check("overflow_count", DW'(overflow_count), DW'(m_ovf));
    endtask

    // driver: one clock, model follows the edge, outputs sampled 1ns later
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        check("rst_tvalid", DW'(axis_if.tvalid), '0);
        check("rst_tdata", axis_if.tdata, '0);
        check("rst_state", DW'(state), '0);
        check("rst_overflow", DW'(overflow_count), '0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        s_data = '0;
        s_valid = 1'b0;
        enable = 1'b0;
        overflow_clear = 1'b0;
        axis_if.tready = 1'b1;
        model_reset();
        #2;
        async_reset();

        // muted stream: tvalid two cycles after the first valid word, all lanes zero
        s_valid = 1'b1;
        s_data = fill(16'h4000);
        step();
        check("first_latency_n1", DW'(axis_if.tvalid), '0);
        step();
        check("first_latency_n2", DW'(axis_if.tvalid), DW'(1));
        check("muted_zero", axis_if.tdata, '0);
        for (int i = 0; i < 4; i++) step();

        // ramp up to g=100, then ramp down to mute from there
        enable = 1'b1;
        for (int i = 0; i < 25; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 24; i++) step();
        check("ramp_down_not_yet_muted", DW'(state), DW'(3));
        step();
        check("ramp_down_muted", DW'(state), '0);
        for (int i = 0; i < 4; i++) step();

        // full ramp to unity, with idle gaps that must hold state and gain
        enable = 1'b1;
        for (int i = 0; i < 80; i++) begin
            s_valid = (i % 5) != 3;
            step();
        end
        s_valid = 1'b1;
        check("active_reached", DW'(state), DW'(2));
        s_data = fill(16'hFFFF);
        s_data[15:0] = 16'h8000;
        s_data[DW-1 -: 16] = 16'h7FFF;
        step();
        step();
        step();
        check("unity_passthrough", axis_if.tdata, s_data);
        for (int i = 0; i < 5; i++) begin
            s_data = rand_word();
            step();
        end

        // downstream stall: held head, drops counted, clear beats a same-cycle drop
        axis_if.tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_data = rand_word();
            step();
        end
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        check("clear_wins", DW'(overflow_count), '0);
        axis_if.tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = rand_word();
            step();
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data = rand_word();
            axis_if.tready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            overflow_clear = ($urandom_range(0, 49) == 0);
            step();
        end
        overflow_clear = 1'b0;

        // reset mid-burst with a partly filled FIFO
        enable = 1'b1;
        s_valid = 1'b1;
        axis_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_data = rand_word();
            step();
        end
        s_valid = 1'b0;
        async_reset();
        axis_if.tready = 1'b1;
        step();
        s_valid = 1'b1;
        s_data = fill(16'h1234);
        step();
        s_valid = 1'b0;
        check("post_reset_n1", DW'(axis_if.tvalid), '0);
        step();
        check("post_reset_n2", DW'(axis_if.tvalid), DW'(1));
        check("post_reset_muted_word", axis_if.tdata, '0);
        for (int i = 0; i < 3; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
